// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the UART-to-ALU command sequencer: opcodes, FSM
// state encoding, framing constants and CMD byte field layout.
package alu_cmd_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_CHK,
    ISSUE,
    WAIT_ACK,
    SEND_ERR,
    SEND
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ERR_BYTE  = 8'hEE;

  localparam int CMD_OPC_LSB = 6;
  localparam int CMD_OP1_LSB = 3;
  localparam int CMD_OP2_LSB = 0;
  localparam int OPC_W       = 2;
  localparam int OPND_W      = 3;

  function automatic logic chk_ok(input logic [7:0] cmd, input logic [7:0] chk);
    return chk == ~cmd;
  endfunction

  // Counter width able to hold (max timeout - 1), the largest value ever loaded.
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the RX, ALU command/response and TX handshake signals seen by the
// sequencer; master is the sequencer side, slave is its environment.
interface alu_cmd_sequencer_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       alu_cmd_valid;
  logic [1:0] alu_opcode;
  logic [2:0] alu_op1;
  logic [2:0] alu_op2;
  logic       alu_cmd_ack;
  logic [7:0] alu_result;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       frame_err;
  logic [7:0] err_count;

  modport master (
    input  rx_valid, rx_data, alu_cmd_ack, alu_result, tx_ready,
    output alu_cmd_valid, alu_opcode, alu_op1, alu_op2,
           tx_valid, tx_data, busy, frame_err, err_count
  );

  modport slave (
    output rx_valid, rx_data, alu_cmd_ack, alu_result, tx_ready,
    input  alu_cmd_valid, alu_opcode, alu_op1, alu_op2,
           tx_valid, tx_data, busy, frame_err, err_count
  );
endinterface

// File: rtl/alu_cmd_sequencer_seq_timeout_timer.sv
// Loadable down-counter shared by the inter-byte and ALU-ack timeouts.
// Expire is high while the count sits at zero.
module seq_timeout_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Frames SYNC/CMD/CHK bytes from the UART into ALU commands and returns one
// response byte (ALU result or error byte) per frame to the UART transmitter.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 100000,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter logic [7:0]  ERR_BYTE     = DEF_ERR_BYTE
) (
  input  logic               clk,
  input  logic               reset,
  alu_cmd_sequencer_if.master bus
);

  localparam int unsigned   TMR_W     = tmr_width(BYTE_TIMEOUT, ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] BYTE_LOAD = TMR_W'(BYTE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'(ACK_TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_cmd;
  logic [7:0]         r_tx_data;
  logic [7:0]         r_err_count;
  logic [OPC_W-1:0]   r_opcode;
  logic [OPND_W-1:0]  r_op1;
  logic [OPND_W-1:0]  r_op2;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_expire;

  seq_timeout_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Timer reloads on every entry to a timed state; a byte or ack beats expiry.
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = BYTE_LOAD;
    case (r_state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          w_next     = GET_CMD;
          w_tmr_load = 1'b1;
        end
      end
      GET_CMD: begin
        if (bus.rx_valid) begin
          w_next     = GET_CHK;
          w_tmr_load = 1'b1;
        end else if (w_expire) begin
          w_next = SEND_ERR;
        end
      end
      GET_CHK: begin
        if (bus.rx_valid)  w_next = chk_ok(r_cmd, bus.rx_data) ? ISSUE : SEND_ERR;
        else if (w_expire) w_next = SEND_ERR;
      end
      ISSUE: begin
        w_next     = WAIT_ACK;
        w_tmr_load = 1'b1;
        w_tmr_val  = ACK_LOAD;
      end
      WAIT_ACK: begin
        if (bus.alu_cmd_ack) w_next = SEND;
        else if (w_expire)   w_next = SEND_ERR;
      end
      SEND_ERR: w_next = SEND;
      SEND:     if (bus.tx_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cmd       <= '0;
      r_tx_data   <= '0;
      r_err_count <= '0;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
    end else begin
      if (r_state == GET_CMD && bus.rx_valid) r_cmd <= bus.rx_data;
      if (r_state == GET_CHK && w_next == ISSUE) begin
        r_opcode <= r_cmd[CMD_OPC_LSB +: OPC_W];
        r_op1    <= r_cmd[CMD_OP1_LSB +: OPND_W];
        r_op2    <= r_cmd[CMD_OP2_LSB +: OPND_W];
      end
      if (r_state == WAIT_ACK && bus.alu_cmd_ack) r_tx_data <= bus.alu_result;
      if (r_state == SEND_ERR) begin
        r_tx_data   <= ERR_BYTE;
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  assign bus.alu_cmd_valid = (r_state == ISSUE);
  assign bus.alu_opcode    = r_opcode;
  assign bus.alu_op1       = r_op1;
  assign bus.alu_op2       = r_op2;
  assign bus.tx_valid      = (r_state == SEND);
  assign bus.tx_data       = r_tx_data;
  assign bus.busy          = (r_state != IDLE);
  assign bus.frame_err     = (r_state == SEND_ERR);
  assign bus.err_count     = r_err_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: table of frames, hand-written
// timing corners and randomized frames against a frame-level reference model.
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  localparam int BT = 20;
  localparam int AT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_err = 0;

  int alu_delay = 0;
  int alu_cd = -1;
  logic [1:0] alu_opc_l;
  logic [2:0] alu_a, alu_b;
  int n_cmd = 0;
  int n_ferr = 0;
  logic [7:0] q_tx[$];
  logic [1:0] last_opc;
  logic [2:0] last_op1, last_op2;

  function automatic logic [7:0] alu_ref(input logic [1:0] opc, input logic [2:0] a, input logic [2:0] b);
    logic [7:0] x, y;
    x = {5'b0, a};
    y = {5'b0, b};
    case (opc)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_MUL:  return x * y;
      default: return (y == 8'd0) ? 8'hFF : x / y;
    endcase
  endfunction

  function automatic logic [7:0] frame_ref(input logic [7:0] cmd, input logic [7:0] chk);
    if (chk != ~cmd) return DEF_ERR_BYTE;
    return alu_ref(cmd[7:6], cmd[5:3], cmd[2:0]);
  endfunction

  // ALU model plus output monitor, both sampling mid-cycle.
  initial begin
    bus.alu_cmd_ack = 1'b0;
    bus.alu_result  = 8'h00;
    forever begin
      @(negedge clk);
      bus.alu_cmd_ack = 1'b0;
      if (alu_cd == 0) begin
        bus.alu_cmd_ack = 1'b1;
        bus.alu_result  = alu_ref(alu_opc_l, alu_a, alu_b);
      end
      if (alu_cd >= 0) alu_cd--;
      if (bus.alu_cmd_valid) begin
        alu_cd = alu_delay;
        alu_opc_l = bus.alu_opcode; alu_a = bus.alu_op1; alu_b = bus.alu_op2;
        last_opc  = bus.alu_opcode; last_op1 = bus.alu_op1; last_op2 = bus.alu_op2;
        n_cmd++;
      end
      if (bus.frame_err) n_ferr++;
      if (bus.tx_valid && bus.tx_ready) q_tx.push_back(bus.tx_data);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_tx(input int hold, output logic [7:0] b);
    int cyc = 0;
    int h = hold;
    bus.tx_ready = (h == 0);
    while (q_tx.size() == 0 && cyc < 200) begin
      if (bus.tx_valid && h > 0) h--;
      bus.tx_ready = (h == 0);
      tick();
      cyc++;
    end
    if (q_tx.size() == 0) begin
      chk("tx_wait_timeout", q_tx.size(), 1);
      b = 8'h00;
    end else begin
      b = q_tx.pop_front();
    end
    bus.tx_ready = 1'b1;
  endtask

  task automatic note_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic wait_flag_tx_valid();
    int cyc = 0;
    while (!bus.tx_valid && cyc < 50) begin tick(); cyc++; end
    chk("tx_valid_seen", bus.tx_valid, 1);
  endtask

  task automatic hold_check(input int n, input logic [7:0] v, inout int bad);
    repeat (n) begin
      if (!bus.tx_valid || bus.tx_data != v) bad++;
      tick();
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] chk;
    logic [7:0] exp_tx;
    bit         exp_issue;
    logic [1:0] exp_opc;
    logic [2:0] exp_op1;
    logic [2:0] exp_op2;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] b, v, cmd, ck, garb, e;
    int n0, f0, cnt, bad, kind, exp_cmd;

    tbl[0] = '{8'h1A, 8'hE5, 8'h05, 1'b1, 2'd0, 3'd3, 3'd2};
    tbl[1] = '{8'hE8, 8'h17, 8'hFF, 1'b1, 2'd3, 3'd5, 3'd0};
    tbl[2] = '{8'h1A, 8'h00, 8'hEE, 1'b0, 2'd0, 3'd0, 3'd0};
    tbl[3] = '{8'h51, 8'hAE, 8'h01, 1'b1, 2'd1, 3'd2, 3'd1};
    tbl[4] = '{8'hBE, 8'h41, 8'h2A, 1'b1, 2'd2, 3'd7, 3'd6};
    tbl[5] = '{8'hA5, 8'h5A, 8'h14, 1'b1, 2'd2, 3'd4, 3'd5};
    tbl[6] = '{8'h4B, 8'hB4, 8'hFE, 1'b1, 2'd1, 3'd1, 3'd3};
    tbl[7] = '{8'hFA, 8'h05, 8'h03, 1'b1, 2'd3, 3'd7, 3'd2};

    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;

    // Reset state
    reset = 1'b0;
    idle(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_cmd_outs", {bus.alu_cmd_valid, bus.alu_opcode, bus.alu_op1, bus.alu_op2}, 0);
    chk("rst_tx_data_ferr", {bus.tx_data, bus.frame_err}, 0);
    reset = 1'b1;
    tick();

    // CHK-to-tx_valid latency, first frame
    send_byte(8'hA5); send_byte(8'h1A); send_byte(8'hE5);
    chk("issue_pulse", bus.alu_cmd_valid, 1);
    cnt = 1;
    while (!bus.tx_valid && cnt < 20) begin tick(); cnt++; end
    chk("latency", cnt, 3);
    wait_tx(0, b);
    chk("lat_tx_data", b, 8'h05);
    chk("lat_idle_after", bus.busy, 0);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      n0 = n_cmd; f0 = n_ferr;
      send_byte(8'hA5); send_byte(tbl[i].cmd); send_byte(tbl[i].chk);
      wait_tx(i % 3, b);
      if (!tbl[i].exp_issue) note_err();
      chk($sformatf("tbl%0d_tx", i), b, tbl[i].exp_tx);
      chk($sformatf("tbl%0d_ncmd", i), n_cmd - n0, tbl[i].exp_issue ? 1 : 0);
      chk($sformatf("tbl%0d_ferr", i), n_ferr - f0, tbl[i].exp_issue ? 0 : 1);
      chk($sformatf("tbl%0d_errcnt", i), bus.err_count, exp_err);
      if (tbl[i].exp_issue)
        chk($sformatf("tbl%0d_fields", i), {last_opc, last_op1, last_op2},
            {tbl[i].exp_opc, tbl[i].exp_op1, tbl[i].exp_op2});
    end

    // Byte timeout, then garbage followed by a good frame
    send_byte(8'hA5);
    cnt = 0;
    while (!bus.frame_err && cnt < 100) begin tick(); cnt++; end
    chk("byte_timeout_cycles", cnt, BT);
    wait_tx(0, b);
    note_err();
    chk("byte_timeout_tx", b, 8'hEE);
    n0 = n_cmd;
    send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h51); send_byte(8'hAE);
    wait_tx(0, b);
    chk("after_timeout_tx", b, 8'h01);
    chk("after_timeout_ncmd", n_cmd - n0, 1);

    // Byte arriving in the expiry cycle wins
    f0 = n_ferr;
    send_byte(8'hA5); idle(BT - 1); send_byte(8'h1A); idle(BT - 1); send_byte(8'hE5);
    wait_tx(0, b);
    chk("byte_wins_tx", b, 8'h05);
    chk("byte_wins_ferr", n_ferr - f0, 0);

    // Backpressure with a dropped frame
    n0 = n_cmd;
    bus.tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h1A); send_byte(8'hE5);
    wait_flag_tx_valid();
    v = bus.tx_data;
    bad = 0;
    hold_check(10, v, bad);
    for (int k = 0; k < 3; k++) begin
      if (!bus.tx_valid || bus.tx_data != v) bad++;
      send_byte((k == 0) ? 8'hA5 : (k == 1) ? 8'h51 : 8'hAE);
    end
    hold_check(37, v, bad);
    chk("bp_stable", bad, 0);
    chk("bp_no_transfer", q_tx.size(), 0);
    chk("bp_ncmd", n_cmd - n0, 1);
    wait_tx(0, b);
    chk("bp_tx", b, 8'h05);
    tick();
    chk("bp_single_transfer", q_tx.size(), 0);
    chk("bp_idle", {bus.busy, bus.tx_valid}, 0);

    // Ack in the last allowed cycle, then one cycle too late
    f0 = n_ferr;
    alu_delay = AT - 1;
    send_byte(8'hA5); send_byte(8'h51); send_byte(8'hAE);
    wait_tx(0, b);
    chk("ack_last_cycle_tx", b, 8'h01);
    alu_delay = AT;
    send_byte(8'hA5); send_byte(8'h51); send_byte(8'hAE);
    wait_tx(0, b);
    note_err();
    chk("ack_late_tx", b, 8'hEE);
    idle(10);
    chk("late_ack_ignored", q_tx.size(), 0);
    chk("late_ack_ferr", n_ferr - f0, 1);

    // ALU never acks
    alu_delay = 100000;
    send_byte(8'hA5); send_byte(8'h1A); send_byte(8'hE5);
    cnt = 0;
    while (!bus.frame_err && cnt < 100) begin tick(); cnt++; end
    chk("ack_timeout_cycles", cnt, AT + 1);
    wait_tx(0, b);
    note_err();
    chk("ack_timeout_tx", b, 8'hEE);
    chk("ack_timeout_errcnt", bus.err_count, exp_err);
    alu_delay = 0;

    // Reset during SEND
    bus.tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h51); send_byte(8'hAE);
    wait_flag_tx_valid();
    reset = 1'b0;
    tick();
    exp_err = 0;
    chk("rst_send_tx_valid", bus.tx_valid, 0);
    chk("rst_send_busy", bus.busy, 0);
    chk("rst_send_errcnt", bus.err_count, 0);
    chk("rst_send_outs", {bus.alu_opcode, bus.alu_op1, bus.alu_op2, bus.tx_data}, 0);
    reset = 1'b1;
    bus.tx_ready = 1'b1;
    idle(5);
    chk("rst_send_nothing_sent", q_tx.size(), 0);

    // Randomized frames against the reference model
    n0 = n_cmd;
    exp_cmd = 0;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 7);
      cmd = 8'($urandom);
      alu_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        garb = 8'($urandom);
        if (garb == 8'hA5) garb = 8'h3C;
        send_byte(garb);
      end
      send_byte(8'hA5);
      if (kind == 0) begin
        idle(BT + 2);
        e = DEF_ERR_BYTE;
      end else begin
        idle($urandom_range(0, 5));
        send_byte(cmd);
        idle($urandom_range(0, 5));
        ck = (kind == 1) ? (~cmd ^ 8'($urandom_range(1, 255))) : ~cmd;
        send_byte(ck);
        e = frame_ref(cmd, ck);
        if (kind != 1) exp_cmd++;
      end
      wait_tx($urandom_range(0, 4), b);
      if (kind <= 1) note_err();
      chk($sformatf("rnd%0d_tx", i), b, e);
      chk($sformatf("rnd%0d_errcnt", i), bus.err_count, exp_err);
    end
    chk("rnd_ncmd", n_cmd - n0, exp_cmd);
    alu_delay = 0;

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      wait_tx(0, b);
      note_err();
      if (i == 100) chk("sat_mid_errcnt", bus.err_count, exp_err);
    end
    chk("sat_errcnt", bus.err_count, 255);
    chk("sat_last_tx", b, 8'hEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Frames UART receive bytes into ALU commands and issues each command to the ALU with a one-cycle cmd_valid pulse. It captures the result and hands one response byte to the UART transmitter over a valid/ready handshake. It sits between the UART RX/TX modules and the ALU and is the only driver of the ALU command inputs. Malformed frames, inter-byte timeouts and missing ALU acks produce an error byte instead of a result.

Parameters:
BYTE_TIMEOUT, 100000, max clk cycles allowed between bytes of one frame (GET_CMD/GET_CHK); ≥2
ACK_TIMEOUT, 16, max clk cycles in WAIT_ACK before declaring an ALU fault; ≥2
SYNC_BYTE, 8'hA5, frame start marker
ERR_BYTE, 8'hEE, response byte sent on any frame/ALU error

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-low
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
alu_cmd_valid  out  1  one-cycle command strobe to ALU
alu_opcode  out  2  ALU opcode (0 add, 1 sub, 2 mul, 3 div)
alu_op1  out  3  operand 1
alu_op2  out  3  operand 2
alu_cmd_ack  in  1  ALU ack; expected 1 cycle after alu_cmd_valid
alu_result  in  8  ALU result; valid in the ack cycle
tx_valid  out  1  response byte available
tx_data  out  8  response byte
tx_ready  in  1  TX can accept; transfer when tx_valid && tx_ready
busy  out  1  high in every state except IDLE
frame_err  out  1  one-cycle pulse per error response generated
err_count  out  8  saturating count of error responses (stops at 255)

Behaviour:
- Frame format: SYNC_BYTE, CMD, CHK. CMD[7:6]=opcode, CMD[5:3]=op1, CMD[2:0]=op2. Frame is valid when CHK == ~CMD.
- Reset (reset==0 at posedge): state IDLE. All outputs 0: alu_cmd_valid, alu_opcode, alu_op1, alu_op2, tx_valid, tx_data, busy, frame_err, err_count. Internal command and timer registers are cleared.
- Reset mid-operation aborts any frame or pending tx without sending anything. Reset has priority over every other event.
- States:
  - IDLE: rx_valid with byte == SYNC_BYTE → GET_CMD. Any other byte is silently dropped.
  - GET_CMD: rx_valid → latch CMD → GET_CHK. Any byte value is a legal CMD, including SYNC_BYTE.
  - GET_CHK: rx_valid → if CHK == ~CMD go to ISSUE, else go to SEND_ERR.
  - Byte timeout: in GET_CMD/GET_CHK the timer reloads on entry and on every rx_valid. If BYTE_TIMEOUT cycles pass with no byte → SEND_ERR.
  - ISSUE (1 cycle): alu_cmd_valid=1, with alu_opcode/op1/op2 driven from CMD → WAIT_ACK.
    - alu_opcode/op1/op2 hold their value until the next ISSUE.
  - WAIT_ACK: alu_cmd_ack → tx_data ← alu_result → SEND.
    - ACK_TIMEOUT cycles without ack → SEND_ERR.
    - A late ack arriving in any other state is ignored.
  - SEND_ERR (1 cycle): tx_data ← ERR_BYTE, frame_err=1, err_count+1 (saturating) → SEND.
  - SEND: tx_valid=1 and tx_data stable until tx_valid && tx_ready. In the transfer cycle → IDLE; tx_valid deasserts the next cycle.
- rx_valid in ISSUE, WAIT_ACK, SEND_ERR or SEND: byte is dropped, not buffered.
- rx_valid in the same cycle a timeout expires: the byte wins and the timer reloads.
- Latency, last CHK byte to tx_valid: nominal 3 cycles (GET_CHK→ISSUE→WAIT_ACK→ack→SEND).
- Divide-by-zero is not an error here: the ALU result (8'hFF) is forwarded unchanged.
- The ALU start_TX output is not consumed by this block; this block alone triggers TX.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - State encoding: IDLE, GET_CMD, GET_CHK, ISSUE, WAIT_ACK, SEND_ERR, SEND.
  - Default SYNC_BYTE and ERR_BYTE.
  - CMD field bit positions.
- One sub-module, seq_timeout_timer: loadable down-counter with load and expire signals, width derived from the larger of the two timeouts. Instantiated once and shared between the byte and ack timeouts.

Test Plan:
- Add, with ALU instance: rx A5,1A,E5 → alu_cmd_valid pulse with opcode 0, op1 3, op2 2; tx_data 8'h05; tx_valid high until tx_ready; err_count 0.
- Div by zero: rx A5,E8,17 → opcode 3, op1 5, op2 0; tx_data 8'hFF; frame_err stays 0.
- Bad checksum: rx A5,1A,00 → no alu_cmd_valid; tx_data 8'hEE; frame_err pulses once; err_count 1.
- Byte timeout, BYTE_TIMEOUT=20: rx A5 then silence → SEND_ERR after 20 cycles; tx 8'hEE. Then rx garbage 3C,A5,51,AE → only the second frame executes (sub 2-1) → tx 8'h01.
- Backpressure and drops: tx_ready held low 50 cycles after a valid frame → tx_valid/tx_data stable throughout. A full frame received meanwhile is dropped (no second alu_cmd_valid). Then raise tx_ready → one transfer, return to IDLE.
- ALU fault and reset: alu_cmd_ack tied 0 → tx 8'hEE after ACK_TIMEOUT cycles. Assert reset during SEND → tx_valid 0 next cycle, all outputs 0, busy 0. Drive 300 errors → err_count saturates at 255.
